// File: rtl/adc_capture_core.sv
// ADC capture core: waits for a programmed start time on the shared timeline,
// captures a fixed number of ADC beats into a buffer FIFO and reports status.
module adc_capture_core #(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int BUF_DEPTH       = 64,
    parameter int BUF_ADDR_WIDTH  = 6
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [63:0]                counter,
    input  logic                       auto_start,
    input  logic                       flush,
    input  logic                       cmd_write,
    input  logic [127:0]               cmd_din,
    input  logic                       rd_en,
    output logic [AXIS_DATA_WIDTH-1:0] rd_data,
    output logic                       rd_valid,
    output logic                       buf_empty,
    output logic                       buf_full,
    output logic [BUF_ADDR_WIDTH:0]    buf_count,
    output logic [63:0]                capture_ts,
    output logic                       busy,
    output logic                       done,
    output logic                       late_error,
    output logic                       overflow_error,
    output logic                       cmd_error
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    localparam logic [BUF_ADDR_WIDTH:0] FULL_COUNT = (BUF_ADDR_WIDTH+1)'(BUF_DEPTH);

    state_t                      state, state_next;
    logic [63:0]                 start_time;
    logic [15:0]                 remaining;
    logic [BUF_ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [AXIS_DATA_WIDTH-1:0]  mem [BUF_DEPTH];

    logic [63:0] cmd_start;
    logic [15:0] cmd_len;
    logic        arm_cmd, zero_len_cmd, bad_cmd, start_hit, beat, last_beat;
    logic        push, pop;

    assign cmd_start     = cmd_din[63:0];
    assign cmd_len       = cmd_din[79:64];
    assign s_axis_tready = 1'b1;
    assign buf_empty     = (buf_count == '0);
    assign buf_full      = (buf_count == FULL_COUNT);
    assign busy          = (state != IDLE);

    always_comb begin
        state_next   = state;
        arm_cmd      = 1'b0;
        zero_len_cmd = 1'b0;
        bad_cmd      = 1'b0;
        start_hit    = 1'b0;
        beat         = 1'b0;
        last_beat    = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_write) begin
                        if (cmd_len == 16'd0) begin
                            zero_len_cmd = 1'b1;
                        end else begin
                            arm_cmd    = 1'b1;
                            state_next = ARMED;
                        end
                    end
                end
                ARMED: begin
                    bad_cmd = cmd_write;
                    if (auto_start && counter >= start_time) begin
                        start_hit  = 1'b1;
                        state_next = CAPTURE;
                    end
                end
                CAPTURE: begin
                    bad_cmd = cmd_write;
                    if (s_axis_tvalid) begin
                        beat = 1'b1;
                        if (remaining == 16'd1) begin
                            last_beat  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A full buffer still accepts a beat when a pop frees a slot in the same cycle.
    assign pop  = rd_en && !buf_empty && !flush;
    assign push = beat && (!buf_full || rd_en);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state          <= IDLE;
            start_time     <= '0;
            remaining      <= '0;
            capture_ts     <= '0;
            done           <= 1'b0;
            late_error     <= 1'b0;
            overflow_error <= 1'b0;
            cmd_error      <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            buf_count      <= '0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
        end else if (flush) begin
            state          <= IDLE;
            capture_ts     <= '0;
            done           <= 1'b0;
            late_error     <= 1'b0;
            overflow_error <= 1'b0;
            cmd_error      <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            buf_count      <= '0;
            rd_valid       <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= zero_len_cmd || last_beat;
            rd_valid <= pop;
            if (arm_cmd || zero_len_cmd) begin
                start_time <= cmd_start;
                remaining  <= cmd_len;
                if (counter > cmd_start) late_error <= 1'b1;
            end
            if (bad_cmd) cmd_error <= 1'b1;
            if (start_hit) capture_ts <= counter;
            if (beat) remaining <= remaining - 16'd1;
            if (beat && !push) overflow_error <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 1'b1;
                2'b01:   buf_count <= buf_count - 1'b1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (push) mem[wr_ptr] <= s_axis_tdata;
    end

endmodule

// File: tb/tb_adc_capture_core.sv
// Directed self-checking bench for adc_capture_core: table-driven arm/capture
// scenarios followed by hand-written overflow, pass-through, flush and reset sequences.
module tb_adc_capture_core;

    localparam int W     = 256;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          s_axi_aclk = 1'b0;
    logic          s_axi_aresetn;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [63:0]   counter;
    logic          auto_start;
    logic          flush;
    logic          cmd_write;
    logic [127:0]  cmd_din;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          buf_empty;
    logic          buf_full;
    logic [AW:0]   buf_count;
    logic [63:0]   capture_ts;
    logic          busy;
    logic          done;
    logic          late_error;
    logic          overflow_error;
    logic          cmd_error;

    int compared   = 0;
    int mismatched = 0;

    adc_capture_core #(
        .AXIS_DATA_WIDTH(W),
        .BUF_DEPTH(DEPTH),
        .BUF_ADDR_WIDTH(AW)
    ) dut (
        .s_axi_aclk(s_axi_aclk),
        .s_axi_aresetn(s_axi_aresetn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .counter(counter),
        .auto_start(auto_start),
        .flush(flush),
        .cmd_write(cmd_write),
        .cmd_din(cmd_din),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .buf_empty(buf_empty),
        .buf_full(buf_full),
        .buf_count(buf_count),
        .capture_ts(capture_ts),
        .busy(busy),
        .done(done),
        .late_error(late_error),
        .overflow_error(overflow_error),
        .cmd_error(cmd_error)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    typedef struct {
        logic [63:0] start;
        logic [15:0] len;
        logic [63:0] c0;
        logic        late;
        logic [63:0] ts;
        logic [63:0] first;
    } vec_t;

    vec_t vecs[4];

    // Every sample beat carries the timeline value it was presented on.
    function automatic logic [W-1:0] beatData(input logic [63:0] c);
        return {4{c}};
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic setCounter(input logic [63:0] c);
        counter      = c;
        s_axis_tdata = beatData(c);
    endtask

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
        setCounter(counter + 64'd1);
    endtask

    task automatic armCmd(input logic [63:0] start, input logic [15:0] len);
        cmd_din   = {48'h0, len, start};
        cmd_write = 1'b1;
        tick();
        cmd_write = 1'b0;
    endtask

    task automatic doFlush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int dones);
        dones = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) dones++;
            if (dones > 0 && !busy) break;
        end
        repeat (3) begin
            tick();
            if (done) dones++;
        end
    endtask

    task automatic drainCheck(input int n, input logic [63:0] first, input string name);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            checkOutput({name, " rd_valid"}, W'(rd_valid), W'(1));
            checkOutput({name, " rd_data"}, rd_data, beatData(first + 64'(i)));
        end
        tick();
        checkOutput({name, " rd_valid low"}, W'(rd_valid), W'(0));
        checkOutput({name, " buf_empty"}, W'(buf_empty), W'(1));
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int    dones;
        string tag;
        tag = $sformatf("vec%0d", idx);
        doFlush();
        setCounter(v.c0);
        armCmd(v.start, v.len);
        checkOutput({tag, " late_error"}, W'(late_error), W'(v.late));
        waitDone(200, dones);
        checkOutput({tag, " done pulses"}, W'(dones), W'(1));
        checkOutput({tag, " busy"}, W'(busy), W'(0));
        checkOutput({tag, " capture_ts"}, W'(capture_ts), W'(v.ts));
        checkOutput({tag, " buf_count"}, W'(buf_count), W'(v.len));
        checkOutput({tag, " overflow"}, W'(overflow_error), W'(0));
        checkOutput({tag, " cmd_error"}, W'(cmd_error), W'(0));
        drainCheck(int'(v.len), v.first, tag);
    endtask

    initial begin
        int          dones;
        int          pops;
        logic [63:0] base;
        logic [63:0] orig;

        vecs[0] = '{start: 64'd100, len: 16'd4, c0: 64'd90,  late: 1'b0, ts: 64'd100, first: 64'd101};
        vecs[1] = '{start: 64'd50,  len: 16'd3, c0: 64'd80,  late: 1'b1, ts: 64'd81,  first: 64'd82};
        vecs[2] = '{start: 64'd200, len: 16'd1, c0: 64'd200, late: 1'b0, ts: 64'd201, first: 64'd202};
        vecs[3] = '{start: 64'd10,  len: 16'd5, c0: 64'd5,   late: 1'b0, ts: 64'd10,  first: 64'd11};

        s_axi_aresetn = 1'b0;
        s_axis_tvalid = 1'b1;
        auto_start    = 1'b1;
        flush         = 1'b0;
        cmd_write     = 1'b0;
        cmd_din       = '0;
        rd_en         = 1'b0;
        setCounter(64'd0);

        repeat (2) @(posedge s_axi_aclk);
        #1;
        checkOutput("reset tready", W'(s_axis_tready), W'(1));
        checkOutput("reset buf_empty", W'(buf_empty), W'(1));
        checkOutput("reset buf_full", W'(buf_full), W'(0));
        checkOutput("reset buf_count", W'(buf_count), W'(0));
        checkOutput("reset busy", W'(busy), W'(0));
        checkOutput("reset done", W'(done), W'(0));
        checkOutput("reset rd_valid", W'(rd_valid), W'(0));
        checkOutput("reset rd_data", rd_data, W'(0));
        checkOutput("reset capture_ts", W'(capture_ts), W'(0));
        checkOutput("reset errors", W'({late_error, overflow_error, cmd_error}), W'(0));
        s_axi_aresetn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

        // Overflow: 70 beats into a 64-entry buffer with no reads.
        doFlush();
        setCounter(64'd1000);
        armCmd(64'd1002, 16'd70);
        waitDone(300, dones);
        checkOutput("ovf done pulses", W'(dones), W'(1));
        checkOutput("ovf buf_full", W'(buf_full), W'(1));
        checkOutput("ovf buf_count", W'(buf_count), W'(64));
        checkOutput("ovf overflow_error", W'(overflow_error), W'(1));
        checkOutput("ovf capture_ts", W'(capture_ts), W'(1002));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checkOutput("ovf first entry", rd_data, beatData(64'd1003));
        checkOutput("ovf count after pop", W'(buf_count), W'(63));

        // Full buffer with rd_en held: every beat is a simultaneous push and pop.
        doFlush();
        setCounter(64'd2000);
        armCmd(64'd2003, 16'd72);
        base  = 64'd2004;
        pops  = 0;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rd_valid) begin
                checkOutput($sformatf("pass pop%0d data", pops), rd_data, beatData(base + 64'(pops)));
                checkOutput($sformatf("pass pop%0d count", pops), W'(buf_count), W'(64));
                pops++;
            end
            if (done) begin
                dones++;
                rd_en = 1'b0;
                break;
            end
            if (buf_full && busy) rd_en = 1'b1;
        end
        rd_en = 1'b0;
        checkOutput("pass done seen", W'(dones), W'(1));
        checkOutput("pass pop total", W'(pops), W'(8));
        checkOutput("pass buf_count", W'(buf_count), W'(64));
        checkOutput("pass overflow_error", W'(overflow_error), W'(0));

        // Re-arm during ARMED is rejected; then flush in the middle of CAPTURE.
        doFlush();
        setCounter(64'd3000);
        orig = 64'd3020;
        armCmd(orig, 16'd10);
        tick();
        tick();
        armCmd(counter, 16'd5);
        checkOutput("rearm cmd_error", W'(cmd_error), W'(1));
        checkOutput("rearm busy", W'(busy), W'(1));
        checkOutput("rearm still armed", W'(capture_ts), W'(0));
        for (int i = 0; i < 50; i++) begin
            if (capture_ts != 64'd0) break;
            tick();
        end
        checkOutput("rearm capture_ts", W'(capture_ts), W'(orig));
        tick();
        tick();
        checkOutput("midcap buf_count", W'(buf_count), W'(2));
        doFlush();
        checkOutput("flush busy", W'(busy), W'(0));
        checkOutput("flush buf_empty", W'(buf_empty), W'(1));
        checkOutput("flush errors", W'({late_error, overflow_error, cmd_error}), W'(0));
        checkOutput("flush capture_ts", W'(capture_ts), W'(0));
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) dones++;
            tick();
        end
        checkOutput("flush no done", W'(dones), W'(0));

        // Zero-length arm: done pulse only, state never leaves IDLE.
        setCounter(64'd4000);
        armCmd(64'd4005, 16'd0);
        checkOutput("len0 done", W'(done), W'(1));
        checkOutput("len0 busy", W'(busy), W'(0));
        checkOutput("len0 buf_count", W'(buf_count), W'(0));
        tick();
        checkOutput("len0 done low", W'(done), W'(0));
        checkOutput("len0 busy after", W'(busy), W'(0));

        // Asynchronous reset while capturing.
        setCounter(64'd5000);
        armCmd(64'd5001, 16'd20);
        repeat (5) tick();
        s_axi_aresetn = 1'b0;
        #1;
        checkOutput("areset busy", W'(busy), W'(0));
        checkOutput("areset buf_empty", W'(buf_empty), W'(1));
        checkOutput("areset capture_ts", W'(capture_ts), W'(0));
        tick();
        s_axi_aresetn = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/adc_capture_core.md
Name: adc_capture_core

Overview:
- Receive-side counterpart of the DAC output path.
- Accepts the RFDC ADC AXI-Stream, waits for a programmed start time on the shared 64-bit timeline counter, then captures a fixed number of sample beats into an internal buffer FIFO.
- The AXI4 front end drains the buffer and reads back capture status.

Parameters:
AXIS_DATA_WIDTH, 256, ADC stream beat width; also the buffer entry width.
BUF_DEPTH, 64, buffer FIFO depth in entries; power of two.
BUF_ADDR_WIDTH, 6, log2(BUF_DEPTH).

Ports:
s_axi_aclk  in  1  single clock for all logic.
s_axi_aresetn  in  1  asynchronous active-low reset.
s_axis_tdata  in  AXIS_DATA_WIDTH  ADC sample beat.
s_axis_tvalid  in  1  beat valid.
s_axis_tready  out  1  ready to ADC.
counter  in  64  global timeline counter.
auto_start  in  1  timeline running; gates the start match.
flush  in  1  synchronous abort and clear.
cmd_write  in  1  arm strobe.
cmd_din  in  128  [63:0] start time, [79:64] beat length, rest ignored.
rd_en  in  1  pop request.
rd_data  out  AXIS_DATA_WIDTH  popped entry.
rd_valid  out  1  rd_data valid.
buf_empty  out  1  buffer empty.
buf_full  out  1  buffer full.
buf_count  out  BUF_ADDR_WIDTH+1  occupancy.
capture_ts  out  64  counter value at capture start.
busy  out  1  state is not IDLE.
done  out  1  one-cycle pulse when capture ends.
late_error  out  1  sticky: start time already passed when armed.
overflow_error  out  1  sticky: beat dropped because the buffer was full.
cmd_error  out  1  sticky: arm attempted while not IDLE.

Behaviour:
- Reset values: all outputs 0 except buf_empty=1 and s_axis_tready=1. State is IDLE; buffer pointers are 0.
- s_axis_tready is held at 1 after reset. The ADC stream is never backpressured.
- IDLE:
  - On cmd_write, latch start_time and length.
  - If length==0: stay in IDLE and pulse done on the next cycle.
  - Otherwise go to ARMED.
  - If counter > start_time in the arm cycle, set late_error.
- ARMED:
  - Leave when auto_start && counter >= start_time.
  - In that cycle, capture_ts <= counter and the state goes to CAPTURE.
  - A late arm therefore starts on the first cycle auto_start is high.
- CAPTURE:
  - Each cycle with s_axis_tvalid=1 counts one beat and decrements remaining.
  - The beat is written to the buffer if (!buf_full || rd_en). Otherwise the beat is dropped, overflow_error is set, and remaining still decrements (the capture window is time-based).
  - Beats with tvalid=0 are not counted.
  - When the final beat is counted, go to IDLE and pulse done in the same cycle the state updates.
- cmd_write while not IDLE: the command is ignored and cmd_error is set.
- Buffer read:
  - rd_en with buf_empty=0 pops an entry. rd_data and rd_valid are registered and appear 1 cycle later; rd_valid is high for 1 cycle.
  - rd_en while empty is ignored and rd_valid stays 0.
- Simultaneous push and pop: buf_count is unchanged, and a push when full with a pop in the same cycle is accepted.
- Pointers wrap modulo BUF_DEPTH. buf_full is asserted when buf_count==BUF_DEPTH.
- flush (synchronous, 1 cycle):
  - Returns the state to IDLE and empties the buffer.
  - Clears all sticky errors, capture_ts and rd_valid.
  - No done pulse.
  - Flush has priority over cmd_write, push and pop in the same cycle.
- Asynchronous reset mid-capture returns all state to the reset values immediately.
- Sticky errors clear only on reset or flush.

Test Plan:
- Arm with start=100, len=4; counter ramps from 90 with auto_start=1 and tvalid always 1 -> capture_ts=100, buffer holds the beats from counter cycles 101..104, done pulses once, buf_count=4, no errors.
- Arm with start=50 while counter=80 -> late_error=1; capture starts the next cycle with capture_ts=81; len beats are captured.
- Capture with len=70 into BUF_DEPTH=64 and no reads -> buf_full after 64 beats, 6 beats dropped, overflow_error=1, done still pulses after 70 counted beats.
- Buffer full, then rd_en held while the capture keeps pushing -> buf_count stays at 64, rd_data returns entries in order with 1-cycle latency, no overflow.
- cmd_write during ARMED -> cmd_error=1, the original start time is kept; then flush mid-CAPTURE -> busy=0, buf_empty=1, all errors 0, no done.
- Arm with len=0 -> done pulses once; busy never asserts; buffer is untouched.
